pulse_cnt_reporter: RTL and testbench

// - Downstream companion of the 4-channel pulse counter bank; drives the bank's shared count enable.
// - Snapshots all four 16-bit counts at the end of each fixed measurement window.
// - Emits per-window deltas (pulses seen in that window) as a 4-beat valid/ready stream, ch0 first.
// - Delta-based, so the counters never need clearing and may wrap freely.

---
 rtl/pulse_cnt_reporter.sv | 147 ++++++++++++++
 tb/tb_pulse_cnt_reporter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_cnt_reporter.sv
`default_nettype none
// ============================================================================
// Module  : pulse_cnt_reporter
// Purpose : Windowed delta reporter for a 4-channel pulse counter bank.
//           Optional o_win_idx port when PULSE_RPT_WINIDX_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module pulse_cnt_reporter #(
   parameter int WINDOW_CYCLES = 1000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic [15:0] i_pulse_cnt1,
   input  logic [15:0] i_pulse_cnt2,
   input  logic [15:0] i_pulse_cnt3,
   input  logic [15:0] i_pulse_cnt4,
   output logic        o_cnt_en,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_data,
   output logic [1:0]  o_ch,
   output logic        o_last,
   output logic        o_overrun,
   output logic        o_busy
`ifdef PULSE_RPT_WINIDX_EN
   ,
   output logic [15:0] o_win_idx
`endif
);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN  = 1'b1} meas_state_t;
   typedef enum logic [0:0] {RIDLE = 1'b0, SEND = 1'b1} rpt_state_t;

   localparam logic [15:0] C_WIN_LAST = 16'(WINDOW_CYCLES - 1);

   meas_state_t r_mstate, w_mstate_nxt;
   rpt_state_t  r_rstate, w_rstate_nxt;
   logic [15:0] r_timer;
   logic [15:0] r_prev  [4];
   logic [15:0] r_delta [4];
   logic [1:0]  r_beat;
   logic        r_overrun;
   logic [15:0] w_cnt   [4];

   logic w_start_acc, w_win_end, w_accept, w_last_acc, w_load, w_drop;

   assign w_cnt[0] = i_pulse_cnt1;
   assign w_cnt[1] = i_pulse_cnt2;
   assign w_cnt[2] = i_pulse_cnt3;
   assign w_cnt[3] = i_pulse_cnt4;

   // i_stop has priority over both i_start and a coincident window end
   assign w_start_acc = (r_mstate == IDLE) & i_start & ~i_stop;
   assign w_win_end   = (r_mstate == RUN) & ~i_stop & (r_timer == C_WIN_LAST);
   assign w_accept    = (r_rstate == SEND) & i_ready;
   assign w_last_acc  = w_accept & (r_beat == 2'd3);
   assign w_load      = w_win_end & ((r_rstate == RIDLE) | w_last_acc);
   assign w_drop      = w_win_end & ~w_load;

   always_comb begin
      w_mstate_nxt = r_mstate;
      w_rstate_nxt = r_rstate;
      case (r_mstate)
         IDLE:    if (w_start_acc) w_mstate_nxt = RUN;
         RUN:     if (i_stop)      w_mstate_nxt = IDLE;
         default: w_mstate_nxt = IDLE;
      endcase
      case (r_rstate)
         RIDLE:   if (w_load)                 w_rstate_nxt = SEND;
         SEND:    if (w_last_acc && !w_load)  w_rstate_nxt = RIDLE;
         default: w_rstate_nxt = RIDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mstate  <= IDLE;
         r_rstate  <= RIDLE;
         r_timer   <= '0;
         r_beat    <= '0;
         r_overrun <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            r_prev[k]  <= '0;
            r_delta[k] <= '0;
         end
      end else begin
         r_mstate <= w_mstate_nxt;
         r_rstate <= w_rstate_nxt;

         if (w_start_acc || i_stop || (r_timer == C_WIN_LAST))
            r_timer <= '0;
         else if (r_mstate == RUN)
            r_timer <= r_timer + 16'd1;

         // prev tracks every window end, including dropped ones
         for (int k = 0; k < 4; k++) begin
            if (w_start_acc || w_win_end)
               r_prev[k] <= w_cnt[k];
            if (w_load)
               r_delta[k] <= w_cnt[k] - r_prev[k];
         end

         if (w_load)
            r_beat <= 2'd0;
         else if (w_accept)
            r_beat <= r_beat + 2'd1;

         if (w_start_acc)
            r_overrun <= 1'b0;
         else if (w_drop)
            r_overrun <= 1'b1;
      end
   end

`ifdef PULSE_RPT_WINIDX_EN
   logic [15:0] r_win_idx;
   logic [15:0] r_rpt_idx;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_win_idx <= '0;
         r_rpt_idx <= '0;
      end else begin
         if (w_start_acc)
            r_win_idx <= '0;
         else if (w_win_end)
            r_win_idx <= r_win_idx + 16'd1;
         if (w_load)
            r_rpt_idx <= r_win_idx;
      end
   end

   assign o_win_idx = r_rpt_idx;
`endif

   assign o_cnt_en  = (r_mstate == RUN);
   assign o_valid   = (r_rstate == SEND);
   assign o_data    = r_delta[r_beat];
   assign o_ch      = r_beat;
   assign o_last    = (r_rstate == SEND) & (r_beat == 2'd3);
   assign o_overrun = r_overrun;
   assign o_busy    = (r_mstate == RUN) | (r_rstate == SEND);

endmodule
`default_nettype wire

// File: tb/tb_pulse_cnt_reporter.sv
`default_nettype none
// Testbench for pulse_cnt_reporter (WINDOW_CYCLES=16); scoreboard of expected beats.
module tb_pulse_cnt_reporter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_stop = 1'b0;
   logic        i_ready = 1'b1;
   logic [15:0] cnt [4];
   logic        o_cnt_en, o_valid, o_last, o_overrun, o_busy;
   logic [15:0] o_data;
   logic [1:0]  o_ch;
`ifdef PULSE_RPT_WINIDX_EN
   logic [15:0] o_win_idx;
`endif

   typedef struct {
      logic [15:0] data;
      logic [1:0]  ch;
      logic        last;
      logic [15:0] idx;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   pulse_cnt_reporter #(.WINDOW_CYCLES(16)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (i_start),
      .i_stop      (i_stop),
      .i_pulse_cnt1(cnt[0]),
      .i_pulse_cnt2(cnt[1]),
      .i_pulse_cnt3(cnt[2]),
      .i_pulse_cnt4(cnt[3]),
      .o_cnt_en    (o_cnt_en),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_data      (o_data),
      .o_ch        (o_ch),
      .o_last      (o_last),
      .o_overrun   (o_overrun),
      .o_busy      (o_busy)
`ifdef PULSE_RPT_WINIDX_EN
      ,
      .o_win_idx   (o_win_idx)
`endif
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick(1);
      i_start = 1'b0;
   endtask

   task automatic pulse_stop();
      i_stop = 1'b1;
      tick(1);
      i_stop = 1'b0;
   endtask

   // advance the counts by d and queue the resulting 4-beat report
   task automatic add_window(input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3,
                             input logic [15:0] idx, input bit expect_rpt);
      logic [15:0] d [4];
      exp_t e;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      for (int k = 0; k < 4; k++) begin
         cnt[k] = cnt[k] + d[k];
         if (expect_rpt) begin
            e.data = d[k];
            e.ch   = 2'(k);
            e.last = (k == 3);
            e.idx  = idx;
            q.push_back(e);
         end
      end
   endtask

   task automatic wait_drain(input int max_cycles);
      int n = 0;
      while (q.size() != 0 && n < max_cycles) begin
         tick(1);
         n++;
      end
      check("drain", 32'(q.size()), 32'd0);
   endtask

   // beat monitor
   always @(negedge clk) begin
      if (!rst && o_valid && i_ready) begin
         if (q.size() == 0) begin
            check("unexpected_beat", {14'd0, o_ch}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("beat_data", {16'd0, o_data}, {16'd0, e.data});
            check("beat_ch",   {30'd0, o_ch},   {30'd0, e.ch});
            check("beat_last", {31'd0, o_last}, {31'd0, e.last});
`ifdef PULSE_RPT_WINIDX_EN
            check("beat_win_idx", {16'd0, o_win_idx}, {16'd0, e.idx});
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 4; k++) cnt[k] = 16'd0;
      tick(3);
      // reset state
      check("rst_cnt_en",  {31'd0, o_cnt_en},  32'd0);
      check("rst_valid",   {31'd0, o_valid},   32'd0);
      check("rst_overrun", {31'd0, o_overrun}, 32'd0);
      check("rst_busy",    {31'd0, o_busy},    32'd0);
      check("rst_data",    {16'd0, o_data},    32'd0);
      check("rst_ch",      {30'd0, o_ch},      32'd0);
      check("rst_last",    {31'd0, o_last},    32'd0);
      rst = 1'b0;
      tick(2);

      // basic: deltas 3/0/5/1, ch3 wraps 0xFFFF -> 0x0000
      cnt[0] = 16'd100; cnt[1] = 16'd200; cnt[2] = 16'd300; cnt[3] = 16'hFFFF;
      pulse_start();
      check("run_cnt_en", {31'd0, o_cnt_en}, 32'd1);
      check("run_busy",   {31'd0, o_busy},   32'd1);
      tick(3);
      add_window(16'd3, 16'd0, 16'd5, 16'd1, 16'd0, 1'b1);
      tick(15);
      pulse_stop();
      wait_drain(40);
      tick(2);
      check("basic_idle_busy",   {31'd0, o_busy},   32'd0);
      check("basic_idle_cnt_en", {31'd0, o_cnt_en}, 32'd0);

      // counter wrap 0xFFFE -> 0x0004
      cnt[0] = 16'hFFFE;
      pulse_start();
      tick(3);
      cnt[0] = 16'h0004;
      q.push_back('{data: 16'h0006, ch: 2'd0, last: 1'b0, idx: 16'd0});
      add_window(16'd0, 16'd7, 16'd8, 16'd9, 16'd0, 1'b0);
      q.push_back('{data: 16'd7, ch: 2'd1, last: 1'b0, idx: 16'd0});
      q.push_back('{data: 16'd8, ch: 2'd2, last: 1'b0, idx: 16'd0});
      q.push_back('{data: 16'd9, ch: 2'd3, last: 1'b1, idx: 16'd0});
      tick(15);
      pulse_stop();
      wait_drain(40);

      // backpressure on beat ch1
      i_ready = 1'b0;
      pulse_start();
      tick(3);
      add_window(16'd10, 16'd20, 16'd30, 16'd40, 16'd0, 1'b1);
      tick(13);
      check("bp_valid_latency", {31'd0, o_valid}, 32'd1);
      check("bp_first_ch",      {30'd0, o_ch},    32'd0);
      i_ready = 1'b1;
      tick(1);
      i_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("bp_hold_valid", {31'd0, o_valid}, 32'd1);
         check("bp_hold_ch",    {30'd0, o_ch},    32'd1);
         check("bp_hold_data",  {16'd0, o_data},  32'd20);
         @(posedge clk);
         #1;
      end
      i_ready = 1'b1;
      tick(2);
      pulse_stop();
      wait_drain(40);

      // overrun: window 2 dropped, window 3 reported correctly
      i_ready = 1'b0;
      pulse_start();
      tick(3);
      add_window(16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 1'b1);
      tick(17);
      check("ovr_not_yet", {31'd0, o_overrun}, 32'd0);
      add_window(16'd50, 16'd50, 16'd50, 16'd50, 16'd1, 1'b0);
      tick(16);
      check("ovr_set", {31'd0, o_overrun}, 32'd1);
      add_window(16'd11, 16'd0, 16'hFFFF, 16'd2, 16'd2, 1'b1);
      i_ready = 1'b1;
      tick(16);
      pulse_stop();
      wait_drain(40);
      check("ovr_sticky", {31'd0, o_overrun}, 32'd1);

      // stop at timer 7: no report
      pulse_start();
      check("start_clears_ovr", {31'd0, o_overrun}, 32'd0);
      tick(7);
      i_stop = 1'b1;
      add_window(16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 1'b0);
      tick(1);
      i_stop = 1'b0;
      check("stop_cnt_en", {31'd0, o_cnt_en}, 32'd0);
      check("stop_busy",   {31'd0, o_busy},   32'd0);
      tick(30);
      // start and stop together in IDLE
      i_start = 1'b1;
      i_stop  = 1'b1;
      tick(1);
      i_start = 1'b0;
      i_stop  = 1'b0;
      check("startstop_cnt_en", {31'd0, o_cnt_en}, 32'd0);
      tick(20);
      check("startstop_busy", {31'd0, o_busy}, 32'd0);

      // reset during beat ch2 of an overrun report
      i_ready = 1'b0;
      pulse_start();
      tick(2);
      add_window(16'd5, 16'd6, 16'd7, 16'd8, 16'd0, 1'b1);
      tick(34);
      check("rstmid_ovr", {31'd0, o_overrun}, 32'd1);
      i_ready = 1'b1;
      begin
         bit found = 1'b0;
         for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (o_valid && o_ch == 2'd2) found = 1'b1;
         end
         check("rstmid_reach_ch2", {31'd0, found}, 32'd1);
      end
      #1;
      rst = 1'b1;
      #1;
      check("rstmid_valid",   {31'd0, o_valid},   32'd0);
      check("rstmid_cnt_en",  {31'd0, o_cnt_en},  32'd0);
      check("rstmid_overrun", {31'd0, o_overrun}, 32'd0);
      q.delete();
      tick(2);
      rst = 1'b0;
      tick(3);
      check("rstmid_after_busy",  {31'd0, o_busy},  32'd0);
      check("rstmid_after_valid", {31'd0, o_valid}, 32'd0);
      check("rstmid_after_ch",    {30'd0, o_ch},    32'd0);
      tick(40);
      check("final_queue", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
